aes_mode_engine: RTL and testbench
==================================

// Module: aes_mode_engine
// PURPOSE
//  Parametrised block-cipher mode wrapper around the existing single-block AES core (start/done handshake).
//  Generalises the CBC-only wrapper: supports ECB, CBC-encrypt and CTR modes, selected per message.
//  Uses valid/ready streaming on input and output with back-pressure, and a per-message block counter.
//  Sits between the bus/register interface and the AES core. Key and IV are latched so callers may change them mid-block.
// PARAMETERS
//  BLOCK_W  128  cipher block width (AES core data/key width)
//  CTR_W    32   width of the CTR-mode increment field (low bits of the counter block), 1..BLOCK_W
//  CNT_W    16   width of the block_count output
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous reset, active-low
//  mode           in   2        0=ECB 1=CBC 2=CTR 3=reserved (handled as ECB); sampled when new_message=1
//  new_message    in   1        qualifies in_valid: this block starts a new message (reload IV, mode, count)
//  key            in   BLOCK_W  cipher key; sampled on every accepted block
//  iv             in   BLOCK_W  CBC IV / CTR initial counter; sampled when new_message=1
//  in_valid       in   1        input block valid
//  in_ready       out  1        engine can accept a block
//  in_data        in   BLOCK_W  plaintext block
//  out_valid      out  1        result block valid
//  out_ready      in   1        downstream accepts result
//  out_data       out  BLOCK_W  ciphertext block
//  block_count    out  CNT_W    blocks completed since last new_message (wraps mod 2^CNT_W)
//  aes_start      out  1        one-cycle start pulse to the AES core
//  aes_done       in   1        AES core completion pulse
//  aes_plaintext  out  BLOCK_W  core input block (registered)
//  aes_key        out  BLOCK_W  core key (registered)
//  aes_ciphertext in   BLOCK_W  core output, valid while aes_done=1
// BEHAVIOUR
//  Reset: state=IDLE; chain, data_reg, key_reg, aes_plaintext, out_data, block_count=0; mode_reg=ECB; in_ready=1, out_valid=0, aes_start=0.
//  Reset mid-operation aborts the block. A late aes_done is ignored because the engine is not in WAIT.
//  FSM IDLE -> START -> WAIT -> OUT -> IDLE. in_ready=1 only in IDLE. At most one block is in flight.
//  IDLE, on in_valid&in_ready:
//    - latch key_reg=key and data_reg=in_data.
//    - if new_message: mode_reg=mode, chain_sel=iv, block_count cleared to 0; else chain_sel=chain.
//    - core input: ECB -> in_data; CBC -> in_data^chain_sel; CTR -> chain_sel. chain<=chain_sel.
//  START: aes_start=1 for exactly one cycle, then go to WAIT. aes_plaintext and aes_key stay stable until aes_done.
//  WAIT, on aes_done:
//    - ECB: out_data=aes_ciphertext.
//    - CBC: out_data=aes_ciphertext; chain=aes_ciphertext.
//    - CTR: out_data=aes_ciphertext^data_reg; chain[CTR_W-1:0]+=1 mod 2^CTR_W; chain[BLOCK_W-1:CTR_W] unchanged (no carry out).
//    - block_count+=1 (wraps); out_valid=1; go to OUT.
//  aes_done outside WAIT is ignored.
//  OUT: out_data and out_valid are held until out_ready=1; that cycle out_valid drops and the engine returns to IDLE.
//    - out_ready high while out_valid=0 has no effect.
//  Latency: accept at cycle t -> aes_start at t+1 -> out_valid one cycle after aes_done.
//    - with out_ready tied high, the next block can be accepted 2 cycles after aes_done.
//  First block after reset with new_message=0 uses mode ECB and chain=0.
//  Changing mode without new_message has no effect.
// STRUCTURE
//  Package aes_mode_pkg:
//    - typedef enum logic [1:0] mode_e {MODE_ECB, MODE_CBC, MODE_CTR, MODE_RSVD}.
//    - typedef enum state_e {IDLE, START, WAIT, OUT}.
//    - localparam AES_BLOCK_W=128.
//  Sub-module aes_ctr_inc: combinational partial-width incrementer (BLOCK_W, CTR_W). Everything else is inline.
// TESTING
//  - ECB, FIPS-197 C.1 key 000102..0f, pt 00112233..eeff with the reference core -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
//  - CBC, SP800-38A F.2.1, 4 blocks, new_message on block 1 only -> 7649abac.., 5086cb9b.., 73bed6b8.., 3ff1caa1..
//  - CTR, SP800-38A F.5.1, IV f0f1..feff, 4 blocks -> 874d6191.., 9806f66b.., 5ae4df3e.., 1e031dda..
//    - also IV low 32 bits ffffffff -> next counter low word 00000000, upper 96 bits unchanged.
//  - Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, no second aes_start.
//  - Reset asserted in WAIT, then aes_done pulses after release -> out_valid stays 0, block_count=0, state IDLE.
//  - CBC 3 blocks, then new CBC message with new_message=1 -> chain restarts from new iv; block_count reads 3, then resets to 0 on accept and reads 1 after the block.

Source files
------------

// File: rtl/aes_mode_pkg.sv
// Shared types and constants for the AES block-cipher mode engine.
package aes_mode_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        MODE_ECB  = 2'd0,
        MODE_CBC  = 2'd1,
        MODE_CTR  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/aes_ctr_inc.sv
// Partial-width counter-block incrementer: the low CTR_W bits count
// modulo 2^CTR_W, the upper bits pass through untouched (no carry out).
module aes_ctr_inc
    import aes_mode_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int CTR_W   = 32
) (
    input  logic [BLOCK_W-1:0] i_blk,
    output logic [BLOCK_W-1:0] o_blk
);

    generate
        if (CTR_W >= BLOCK_W) begin : g_full
            // Increment field spans the whole block
            always_comb o_blk = i_blk + BLOCK_W'(1);
        end else begin : g_part
            // Increment only the low field, keep the nonce part
            always_comb o_blk = {i_blk[BLOCK_W-1:CTR_W], i_blk[CTR_W-1:0] + CTR_W'(1)};
        end
    endgenerate

endmodule

// File: rtl/aes_mode_engine.sv
// ECB / CBC-encrypt / CTR mode wrapper around a single-block AES core
// with a start/done handshake, valid/ready streaming on both sides and
// a per-message completed-block counter. One block in flight at a time.
module aes_mode_engine
    import aes_mode_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int CTR_W   = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               new_message,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic [CNT_W-1:0]   block_count,
    output logic               aes_start,
    input  logic               aes_done,
    output logic [BLOCK_W-1:0] aes_plaintext,
    output logic [BLOCK_W-1:0] aes_key,
    input  logic [BLOCK_W-1:0] aes_ciphertext
);

    state_e             r_state;
    mode_e              r_mode;
    logic [BLOCK_W-1:0] r_chain;
    logic [BLOCK_W-1:0] r_data;
    logic [BLOCK_W-1:0] r_key;
    logic [BLOCK_W-1:0] r_pt;
    logic [BLOCK_W-1:0] r_out;
    logic [CNT_W-1:0]   r_count;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_start;

    mode_e              w_mode_sel;
    logic [BLOCK_W-1:0] w_chain_sel;
    logic [BLOCK_W-1:0] w_core_in;
    logic [BLOCK_W-1:0] w_chain_inc;
    logic [BLOCK_W-1:0] w_result;

    aes_ctr_inc #(
        .BLOCK_W (BLOCK_W),
        .CTR_W   (CTR_W)
    ) u_ctr_inc (
        .i_blk (r_chain),
        .o_blk (w_chain_inc)
    );

    // Select mode/chain for the incoming block and form the core input
    always_comb begin
        w_mode_sel  = new_message ? mode_e'(mode) : r_mode;
        w_chain_sel = new_message ? iv : r_chain;
        case (w_mode_sel)
            MODE_CBC: w_core_in = in_data ^ w_chain_sel;
            MODE_CTR: w_core_in = w_chain_sel;
            default:  w_core_in = in_data;
        endcase
    end

    // Post-process the core output into the result block
    always_comb begin
        if (r_mode == MODE_CTR) w_result = aes_ciphertext ^ r_data;
        else                    w_result = aes_ciphertext;
    end

    // Control FSM with all datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE_ECB;
            r_chain     <= '0;
            r_data      <= '0;
            r_key       <= '0;
            r_pt        <= '0;
            r_out       <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_key      <= key;
                        r_data     <= in_data;
                        r_mode     <= w_mode_sel;
                        r_chain    <= w_chain_sel;
                        r_pt       <= w_core_in;
                        if (new_message) r_count <= '0;
                        r_in_ready <= 1'b0;
                        r_start    <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_start <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (aes_done) begin
                        r_out <= w_result;
                        if (r_mode == MODE_CBC) r_chain <= aes_ciphertext;
                        if (r_mode == MODE_CTR) r_chain <= w_chain_inc;
                        r_count     <= r_count + CNT_W'(1);
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out;
    assign block_count   = r_count;
    assign aes_start     = r_start;
    assign aes_plaintext = r_pt;
    assign aes_key       = r_key;

endmodule

// File: tb/tb_aes_mode_engine.sv
// Bench for aes_mode_engine: behavioural AES-128 core stand-in, known-answer
// vectors for ECB/CBC/CTR, and randomized messages against a mode model.
module tb_aes_mode_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic         new_message;
    logic [127:0] key;
    logic [127:0] iv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [15:0]  block_count;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_plaintext;
    logic [127:0] aes_key;
    logic [127:0] aes_ciphertext;

    aes_mode_engine #(
        .BLOCK_W (128),
        .CTR_W   (32),
        .CNT_W   (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .new_message    (new_message),
        .key            (key),
        .iv             (iv),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .block_count    (block_count),
        .aes_start      (aes_start),
        .aes_done       (aes_done),
        .aes_plaintext  (aes_plaintext),
        .aes_key        (aes_key),
        .aes_ciphertext (aes_ciphertext)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int core_lat = 2;
    int n_starts = 0;

    logic [7:0] sbox [256];

    // mode model state
    logic [1:0]   m_mode;
    logic [127:0] m_chain;
    int           m_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Plain FIPS-197 AES-128 encryption, bytes numbered MSB first
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c+rr] = sbox[s[4*((c+rr)%4)+rr]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int b = 0; b < 16; b++) s[b] ^= w[4*rd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) r[127-8*b -: 8] = s[b];
        return r;
    endfunction

    // Count every cycle with aes_start high
    always @(negedge clk) if (aes_start === 1'b1) n_starts++;

    // AES core stand-in: latches inputs on start, answers after core_lat cycles
    initial begin
        logic [127:0] cpt, ckey;
        aes_done = 1'b0;
        aes_ciphertext = '0;
        forever begin
            @(negedge clk);
            aes_ciphertext = rnd128();
            if (aes_start === 1'b1) begin
                cpt  = aes_plaintext;
                ckey = aes_key;
                repeat (core_lat - 1) begin
                    @(negedge clk);
                    aes_ciphertext = rnd128();
                end
                @(negedge clk);
                aes_done = 1'b1;
                aes_ciphertext = aes_enc(ckey, cpt);
                @(negedge clk);
                aes_done = 1'b0;
                aes_ciphertext = rnd128();
            end
        end
    end

    // One block through the engine, checked against the mode model
    task automatic xfer(input logic [1:0] m, input logic nm, input logic [127:0] k,
                        input logic [127:0] v, input logic [127:0] d, input int hold,
                        input string tag, output logic [127:0] res);
        logic [127:0] exp_core, exp_out, ct;
        logic [1:0]   em;
        int g, s0;
        g = 0;
        while (in_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; end
        chk({tag, "/in_ready"}, in_ready, 1);
        chk({tag, "/count_before"}, block_count, m_cnt);
        if (nm) begin m_mode = m; m_chain = v; m_cnt = 0; end
        em = (m_mode == 2'd1 || m_mode == 2'd2) ? m_mode : 2'd0;
        case (em)
            2'd1:    exp_core = d ^ m_chain;
            2'd2:    exp_core = m_chain;
            default: exp_core = d;
        endcase
        ct = aes_enc(k, exp_core);
        case (em)
            2'd1: begin exp_out = ct; m_chain = ct; end
            2'd2: begin exp_out = ct ^ d; m_chain[31:0] = m_chain[31:0] + 32'd1; end
            default: exp_out = ct;
        endcase
        m_cnt = (m_cnt + 1) % 65536;
        mode = m; new_message = nm; key = k; iv = v; in_data = d; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; new_message = 1'b0;
        key = rnd128(); iv = rnd128(); mode = 2'($urandom_range(0, 3)); in_data = rnd128();
        if (hold == 0 && $urandom_range(0, 1) == 1) out_ready = 1'b1;
        chk({tag, "/aes_start"}, aes_start, 1);
        chk({tag, "/in_ready_busy"}, in_ready, 0);
        chk({tag, "/aes_plaintext"}, aes_plaintext, exp_core);
        chk({tag, "/aes_key"}, aes_key, k);
        if (nm) chk({tag, "/count_cleared"}, block_count, 0);
        g = 0;
        while (out_valid !== 1'b1 && g < 200) begin @(negedge clk); g++; end
        chk({tag, "/out_valid"}, out_valid, 1);
        res = out_data;
        chk({tag, "/out_data"}, out_data, exp_out);
        chk({tag, "/count_after"}, block_count, m_cnt);
        if (hold > 0) begin
            s0 = n_starts;
            repeat (hold) begin
                @(negedge clk);
                chk({tag, "/hold_data"}, out_data, res);
                chk({tag, "/hold_valid"}, out_valid, 1);
                chk({tag, "/hold_in_ready"}, in_ready, 0);
            end
            chk({tag, "/hold_no_start"}, n_starts, s0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r, K, CIV, TIV, up_iv;
        logic [127:0] P [4];
        logic [127:0] CBC_C [4];
        logic [127:0] CTR_C [4];
        logic [7:0]   inv, sb;
        int seen;

        // S-box from GF(2^8) inverse and the affine map
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x] = sb;
        end

        K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        CIV = 128'h000102030405060708090a0b0c0d0e0f;
        TIV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        P[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        P[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        P[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        P[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        CBC_C[0] = 128'h7649abac8119b246cee98e9b12e9197d;
        CBC_C[1] = 128'h5086cb9b507219ee95db113a917678b2;
        CBC_C[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
        CBC_C[3] = 128'h3ff1caa1681fac09120eca307586e1a7;
        CTR_C[0] = 128'h874d6191b620e3261bef6864990db6ce;
        CTR_C[1] = 128'h9806f66b7970fdff8617187bb9fffdff;
        CTR_C[2] = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
        CTR_C[3] = 128'h1e031dda2fbe03d1792170a0f3009cee;

        rst = 1'b0; mode = 2'd0; new_message = 1'b0; key = '0; iv = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_mode = 2'd0; m_chain = '0; m_cnt = 0;
        repeat (3) @(negedge clk);
        chk("reset/in_ready", in_ready, 1);
        chk("reset/out_valid", out_valid, 0);
        chk("reset/aes_start", aes_start, 0);
        chk("reset/block_count", block_count, 0);
        chk("reset/out_data", out_data, 0);
        chk("reset/aes_plaintext", aes_plaintext, 0);
        chk("reset/aes_key", aes_key, 0);
        rst = 1'b1;
        @(negedge clk);

        // First block without new_message: ECB, CBC request ignored
        xfer(2'd1, 1'b0, rnd128(), rnd128(), rnd128(), 0, "first_nomsg", r);

        xfer(2'd0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
             rnd128(), 128'h00112233445566778899aabbccddeeff, 0, "fips_ecb", r);
        chk("fips_ecb/kat", r, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        for (int i = 0; i < 4; i++) begin
            xfer(2'd1, i == 0, K, CIV, P[i], 0, "cbc_kat", r);
            chk("cbc_kat/vector", r, CBC_C[i]);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(2'd2, i == 0, K, TIV, P[i], 0, "ctr_kat", r);
            chk("ctr_kat/vector", r, CTR_C[i]);
        end

        // CTR low word wraps without carrying into the nonce
        up_iv = rnd128();
        xfer(2'd2, 1'b1, K, {up_iv[127:32], 32'hffffffff}, rnd128(), 0, "ctr_wrap0", r);
        xfer(2'd2, 1'b0, K, rnd128(), rnd128(), 0, "ctr_wrap1", r);
        chk("ctr_wrap/counter", aes_plaintext, {up_iv[127:32], 32'h00000000});

        // Back-pressure on the result
        xfer(2'd0, 1'b1, rnd128(), rnd128(), rnd128(), 10, "backpressure", r);

        // CBC message of 3, then a fresh CBC message restarts chain and count
        for (int i = 0; i < 3; i++) xfer(2'd1, i == 0, K, rnd128(), rnd128(), 0, "cbc3", r);
        chk("cbc3/count3", block_count, 3);
        xfer(2'd1, 1'b1, K, rnd128(), rnd128(), 0, "cbc_restart", r);
        chk("cbc_restart/count1", block_count, 1);

        // Reset while waiting on the core; its late done must be ignored
        core_lat = 8;
        mode = 2'd1; new_message = 1'b1; key = rnd128(); iv = rnd128(); in_data = rnd128();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; new_message = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk("rst_wait/out_valid_seen", seen, 0);
        chk("rst_wait/block_count", block_count, 0);
        chk("rst_wait/in_ready", in_ready, 1);
        m_mode = 2'd0; m_chain = '0; m_cnt = 0;
        core_lat = 2;
        xfer(2'd2, 1'b0, rnd128(), rnd128(), rnd128(), 0, "after_rst", r);

        // Randomized messages
        for (int i = 0; i < 30; i++) begin
            core_lat = $urandom_range(1, 4);
            xfer(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), rnd128(), rnd128(),
                 rnd128(), 0, "random", r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
